// File: rtl/result_writer_pkg.sv
// -----------------------------------------------------------------------------
// result_writer_pkg
// Shared definitions for the result writer slice:
//   - state_t        : writer FSM states (IDLE, RUN, DONE)
//   - DEF_*          : default geometry constants used as parameter defaults
//   - clog2_min1()   : $clog2 that never returns 0, for counter/pointer widths
// Optional feature macro used by this slice: RESULT_CHECKSUM_EN
// -----------------------------------------------------------------------------
package result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_PIX_W         = 8;
  localparam int DEF_PIX_PER_BEAT  = 36;
  localparam int DEF_BEATS_PER_ROW = 18;
  localparam int DEF_OUT_ROWS      = 480;

  // Width helper: a one-entry range still needs a one-bit register.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Small synchronous skid FIFO with show-ahead head output.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous flush; a push in the same cycle lands as entry 0
//   push, din  : write request and data (accepted when not full, or when full
//                and a pop happens in the same cycle)
//   pop        : remove head (ignored when empty or during clr)
//   dout       : current head entry (valid only when !empty)
//   full/empty : occupancy flags
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module result_fifo
  import result_writer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    wr_idx;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty && !clr;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (clr || !full || do_pop);
  assign wr_idx  = clr ? '0 : wr_ptr_reg[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= do_push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers only.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_idx] <= din;
  end

  // Show-ahead read so a beat written at edge t is presented in cycle t+1.
  assign dout = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/result_writer.sv
// -----------------------------------------------------------------------------
// result_writer
// Captures one frame of pixel beats and writes them, in arrival order, to a
// result memory at word address row*BEATS_PER_ROW + col. A skid FIFO absorbs
// memory stalls; beats arriving on a full FIFO are dropped and flagged.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : pulse; arms (IDLE/DONE) or restarts (RUN) a frame
//   valid, pixel_in     : input beat, first pixel in MSBs, no backpressure
//   mem_ready           : memory accepts the write this cycle
//   mem_we, mem_addr,
//   mem_wdata           : memory write request (FIFO head)
//   busy / done         : FSM in RUN / in DONE
//   overflow            : sticky, a beat was dropped on a full FIFO
//   checksum            : (RESULT_CHECKSUM_EN only) mod-2^32 sum of all pixels
//                         of completed writes since the last start
// Optional feature macro: RESULT_CHECKSUM_EN
// -----------------------------------------------------------------------------
module result_writer
  import result_writer_pkg::*;
#(
  parameter int PIX_W         = DEF_PIX_W,
  parameter int PIX_PER_BEAT  = DEF_PIX_PER_BEAT,
  parameter int BEATS_PER_ROW = DEF_BEATS_PER_ROW,
  parameter int OUT_ROWS      = DEF_OUT_ROWS,
  parameter int ADDR_W        = 14,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          valid,
  input  logic [PIX_W*PIX_PER_BEAT-1:0] pixel_in,
  input  logic                          mem_ready,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [PIX_W*PIX_PER_BEAT-1:0] mem_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [31:0]                   checksum
`endif
);

  localparam int BEAT_W = PIX_W * PIX_PER_BEAT;
  localparam int TOTAL  = BEATS_PER_ROW * OUT_ROWS;
  localparam int ACC_W  = $clog2(TOTAL + 1);
  localparam int COL_W  = clog2_min1(BEATS_PER_ROW);
  localparam int ROW_W  = clog2_min1(OUT_ROWS) + 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(OUT_ROWS - 1);
  localparam logic [ACC_W-1:0] ACC_TOTAL = ACC_W'(TOTAL);

  state_t              state_reg;
  state_t              state_next;
  logic [ACC_W-1:0]    accept_cnt_reg;
  logic [COL_W-1:0]    col_reg;
  logic [ROW_W-1:0]    row_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                overflow_reg;

  logic                fifo_push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [BEAT_W-1:0]   fifo_dout;
  logic                write_fire;
  logic                last_write;
  logic                accept_ok;
  logic                run_beat;
  logic                drop;

  result_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .push  (fifo_push),
    .pop   (write_fire),
    .din   (pixel_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg == RUN);
    done       = (state_reg == DONE);
    mem_we     = (state_reg == RUN) && !fifo_empty;
    write_fire = mem_we && mem_ready;
    last_write = write_fire && (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    unique case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if (start)           state_next = RUN;
        else if (last_write) state_next = DONE;
      end
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat admission. A start flushes the FIFO and the coincident beat becomes
  // beat 0 of the new frame. Dropped beats still count towards the frame.
  // ---------------------------------------------------------------------------
  assign accept_ok = (accept_cnt_reg < ACC_TOTAL);
  assign run_beat  = valid && (state_reg == RUN) && accept_ok;
  assign fifo_push = valid && (start || run_beat);
  assign drop      = run_beat && !start && fifo_full && !write_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt_reg <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      addr_reg       <= '0;
      overflow_reg   <= 1'b0;
    end else if (start) begin
      accept_cnt_reg <= valid ? ACC_W'(1) : '0;
      col_reg        <= '0;
      row_reg        <= '0;
      addr_reg       <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (run_beat) accept_cnt_reg <= accept_cnt_reg + ACC_W'(1);
      if (drop)     overflow_reg   <= 1'b1;
      if (write_fire) begin
        // Writes are strictly sequential, so a running address equals
        // row*BEATS_PER_ROW + col without a multiplier.
        addr_reg <= addr_reg + ADDR_W'(1);
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = mem_we ? fifo_dout : '0;
  assign overflow  = overflow_reg;

`ifdef RESULT_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Frame checksum over every pixel of every completed write.
  // ---------------------------------------------------------------------------
  logic [31:0] beat_sum;
  logic [31:0] checksum_reg;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < PIX_PER_BEAT; i++) begin
      beat_sum = beat_sum + 32'(fifo_dout[i*PIX_W +: PIX_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          checksum_reg <= '0;
    else if (start)      checksum_reg <= '0;
    else if (write_fire) checksum_reg <= checksum_reg + beat_sum;
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_result_writer.sv
// -----------------------------------------------------------------------------
// tb_result_writer
// Directed bench for result_writer with default geometry (18 x 480 beats of
// 36 8-bit pixels). A negedge monitor logs every completed memory write; the
// linear stimulus below compares DUT outputs and the write log against
// hand-derived values. Checksum test only when RESULT_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_result_writer;

  localparam int PW    = 8;
  localparam int PPB   = 36;
  localparam int BW    = PW * PPB;
  localparam int BPR   = 18;
  localparam int ROWS  = 480;
  localparam int TOTAL = BPR * ROWS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          valid;
  logic [BW-1:0] pixel_in;
  logic          mem_ready;
  logic          mem_we;
  logic [13:0]   mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [13:0]   log_addr [$];
  logic [BW-1:0] log_data [$];

  result_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .valid     (valid),
    .pixel_in  (pixel_in),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
`ifdef RESULT_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logs the write that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  function automatic logic [BW-1:0] beat(input int k);
    logic [BW-1:0] b;
    logic [7:0]    p;
    p = k[7:0];
    for (int i = 0; i < PPB; i++) b[i*PW +: PW] = p;
    return b;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k);
    valid    = 1'b1;
    pixel_in = beat(k);
  endtask

  initial begin
    int bad;
    int n_before;

    rst_n = 1'b0; start = 1'b0; valid = 1'b0; pixel_in = '0; mem_ready = 1'b1;
    tick; tick;
    check("rst_mem_we",   BW'(mem_we),    '0);
    check("rst_addr",     BW'(mem_addr),  '0);
    check("rst_wdata",    mem_wdata,      '0);
    check("rst_busy",     BW'(busy),      '0);
    check("rst_done",     BW'(done),      '0);
    check("rst_overflow", BW'(overflow),  '0);
`ifdef RESULT_CHECKSUM_EN
    check("rst_checksum", BW'(checksum),  '0);
`endif
    rst_n = 1'b1;

    // Beats in IDLE are ignored.
    send(7); tick; tick; valid = 1'b0;
    check("idle_ignore_we", BW'(mem_we), '0);
    check("idle_busy",      BW'(busy),   '0);
    tick;
    check("idle_no_log",    BW'(log_addr.size()), '0);

    // Full frame: start coincides with beat 0, back-to-back beats.
    start = 1'b1; send(0); tick; start = 1'b0;
    check("first_latency_we", BW'(mem_we),   BW'(1));
    check("first_addr",       BW'(mem_addr), '0);
    check("first_data",       mem_wdata,     beat(0));
    check("run_busy",         BW'(busy),     BW'(1));
    for (int k = 1; k < TOTAL; k++) begin
      send(k); tick;
    end
    check("last_pending_done", BW'(done),     '0);
    check("last_addr",         BW'(mem_addr), BW'(TOTAL - 1));
    send(0); tick;                         // surplus beat, must be ignored
    check("done_after_last", BW'(done), BW'(1));
    check("busy_after_last", BW'(busy), '0);
    tick; tick; valid = 1'b0;
    check("done_hold",      BW'(done),     BW'(1));
    check("done_no_we",     BW'(mem_we),   '0);
    check("frame_overflow", BW'(overflow), '0);
    check("frame_writes",   BW'(log_addr.size()), BW'(TOTAL));
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_addr[i] !== 14'(i) || log_data[i] !== beat(i)) bad++;
    check("frame_order",    BW'(bad), '0);
    if (log_addr.size() > 18)
      check("row_wrap_addr", BW'(log_addr[18]), BW'(18));
    else
      check("row_wrap_present", BW'(log_addr.size()), BW'(TOTAL));
    log_addr.delete(); log_data.delete();

    // Stall with 4 beats: all absorbed, head held.
    start = 1'b1; tick; start = 1'b0;
    check("restart_done_clr", BW'(done), '0);
    check("restart_busy",     BW'(busy), BW'(1));
    for (int i = 0; i < 5; i++) begin send(100 + i); tick; end
    valid = 1'b0; tick; tick;
    mem_ready = 1'b0;
    bad = 0;
    for (int i = 5; i < 9; i++) begin
      send(100 + i); tick;
      if (mem_we !== 1'b1 || mem_addr !== 14'd5 || mem_wdata !== beat(105)) bad++;
    end
    valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (mem_we !== 1'b1 || mem_addr !== 14'd5 || mem_wdata !== beat(105)) bad++;
    end
    check("stall_hold",     BW'(bad),      '0);
    check("stall_overflow", BW'(overflow), '0);
    mem_ready = 1'b1;
    repeat (5) tick;
    check("stall_writes", BW'(log_addr.size()), BW'(9));
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_addr[i] !== 14'(i) || log_data[i] !== beat(100 + i)) bad++;
    check("stall_order", BW'(bad), '0);
    log_addr.delete(); log_data.delete();

    // Stall with 6 beats: two dropped, no address gap.
    start = 1'b1; tick; start = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin send(200 + i); tick; end
    valid = 1'b0;
    check("ovf_set", BW'(overflow), BW'(1));
    mem_ready = 1'b1;
    repeat (5) tick;
    check("ovf_writes", BW'(log_addr.size()), BW'(4));
    check("ovf_sticky", BW'(overflow), BW'(1));
    send(206); tick; valid = 1'b0; tick; tick;
    check("ovf_writes_after", BW'(log_addr.size()), BW'(5));
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_addr[i] !== 14'(i) || log_data[i] !== beat((i < 4) ? 200 + i : 206)) bad++;
    check("ovf_order", BW'(bad), '0);
    start = 1'b1; tick; start = 1'b0;
    check("ovf_clear_on_start", BW'(overflow), '0);
    log_addr.delete(); log_data.delete();

    // Reset in the middle of a frame.
    for (int k = 0; k < 100; k++) begin send(k); tick; end
    send(100); rst_n = 1'b0; #1;
    n_before = log_addr.size();
    check("midrst_we",   BW'(mem_we),   '0);
    check("midrst_busy", BW'(busy),     '0);
    check("midrst_addr", BW'(mem_addr), '0);
    tick; rst_n = 1'b1;
    tick; tick; tick; valid = 1'b0; tick;
    check("post_rst_no_write", BW'(log_addr.size()), BW'(n_before));
    check("post_rst_busy",     BW'(busy), '0);
    start = 1'b1; tick; start = 1'b0;
    check("restart_empty_we", BW'(mem_we), '0);
    send(55); tick; valid = 1'b0;
    check("rst_first_we",   BW'(mem_we),   BW'(1));
    check("rst_first_addr", BW'(mem_addr), '0);
    check("rst_first_data", mem_wdata,     beat(55));
    tick; tick;

`ifdef RESULT_CHECKSUM_EN
    // All-0xFF frame checksum.
    start = 1'b1; send(255); tick; start = 1'b0;
    repeat (TOTAL - 1) tick;
    valid = 1'b0; tick;
    check("cks_done",  BW'(done),     BW'(1));
    check("cks_value", BW'(checksum), BW'(32'd311040 * 32'd255));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
